// File: rtl/top_seven.sv
// top_seven: 7x7 Conway Game of Life engine (B3/S23, dead border) with a
// two-button serial cell loader and play/pause control. One generation is
// computed per clock while running; board and state are exported registered.
module top_seven (
  input  logic        in_clka,
  input  logic        in_stop,
  input  logic        in_clkb,
  input  logic        in_prgm,
  input  logic        in_pp,
  input  logic        in_btn0,
  input  logic        in_btn1,
  output logic [1:0]  out_game_state,
  output logic [48:0] out_grid
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PROGRAM = 2'b01,
    ST_RUN     = 2'b10,
    ST_PAUSE   = 2'b11
  } game_state_t;

  game_state_t state_q, state_d;
  logic [48:0] grid_q, grid_d;
  logic [48:0] grid_next_gen;
  logic [5:0]  cursor_q, cursor_d;
  logic        pp_q;
  logic        pp_edge;
  logic        single_btn;
  logic [80:0] pad;
  logic [3:0]  count;
  logic        alive;
  logic        unused_clkb;

  // Legacy second-phase pin: deliberately not used for anything.
  assign unused_clkb = in_clkb;

  assign pp_edge    = in_pp & ~pp_q;
  assign single_btn = in_btn0 ^ in_btn1;

  assign out_game_state = state_q;
  assign out_grid       = grid_q;

  // Embed the board in a 9x9 frame of dead cells so every cell sees eight
  // in-range neighbours and edges need no special casing.
  always_comb begin
    pad = '0;
    for (int unsigned r = 0; r < 7; r++) begin
      for (int unsigned c = 0; c < 7; c++) begin
        pad[(r + 1) * 9 + c + 1] = grid_q[r * 7 + c];
      end
    end
  end

  // Next generation for all 49 cells in parallel.
  always_comb begin
    grid_next_gen = '0;
    count         = '0;
    alive         = 1'b0;
    for (int unsigned r = 0; r < 7; r++) begin
      for (int unsigned c = 0; c < 7; c++) begin
        count = '0;
        for (int unsigned dr = 0; dr < 3; dr++) begin
          for (int unsigned dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1)) begin
              count = count + {3'b000, pad[(r + dr) * 9 + c + dc]};
            end
          end
        end
        alive = pad[(r + 1) * 9 + c + 1];
        grid_next_gen[r * 7 + c] = (count == 4'd3) | (alive & (count == 4'd2));
      end
    end
  end

  // Game-state transitions plus the grid and cursor updates they imply.
  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    cursor_d = cursor_q;
    case (state_q)
      ST_IDLE: begin
        if (in_prgm) begin
          state_d  = ST_PROGRAM;
          cursor_d = '0;
        end else if (pp_edge) begin
          state_d = ST_RUN;
        end
      end
      ST_PROGRAM: begin
        if (pp_edge) begin
          state_d  = ST_RUN;
          cursor_d = '0;
        end else if (single_btn) begin
          grid_d[cursor_q] = in_btn1;
          cursor_d = (cursor_q == 6'd48) ? '0 : cursor_q + 6'd1;
        end
      end
      ST_RUN: begin
        if (in_prgm) begin
          state_d  = ST_PROGRAM;
          cursor_d = '0;
        end else if (pp_edge) begin
          state_d = ST_PAUSE;
        end else begin
          grid_d = grid_next_gen;
        end
      end
      ST_PAUSE: begin
        if (in_prgm) begin
          state_d  = ST_PROGRAM;
          cursor_d = '0;
        end else if (pp_edge) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, board, cursor and play/pause history registers.
  always_ff @(posedge in_clka) begin
    if (in_stop) begin
      state_q  <= ST_IDLE;
      grid_q   <= '0;
      cursor_q <= '0;
      pp_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      cursor_q <= cursor_d;
      pp_q     <= in_pp;
    end
  end

endmodule

// File: tb/tb_top_seven.sv
// Directed self-checking bench for top_seven.
module tb_top_seven;

  logic        clk;
  logic        stop, clkb, prgm, pp, btn0, btn1;
  logic [1:0]  game_state;
  logic [48:0] grid;

  int vectors;
  int miscompares;

  localparam logic [48:0] H_BLINK = 49'h0000003800000;
  localparam logic [48:0] V_BLINK = 49'h0000081020000;

  top_seven dut (
    .in_clka        (clk),
    .in_stop        (stop),
    .in_clkb        (clkb),
    .in_prgm        (prgm),
    .in_pp          (pp),
    .in_btn0        (btn0),
    .in_btn1        (btn1),
    .out_game_state (game_state),
    .out_grid       (grid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, pass one rising edge, return 1 time unit after it.
  task automatic step(input logic s, input logic pr, input logic p,
                      input logic b0, input logic b1);
    stop = s; prgm = pr; pp = p; btn0 = b0; btn1 = b1;
    clkb = ~clkb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_out(input string name, input logic [1:0] exp_state,
                           input logic [48:0] exp_grid);
    vectors++;
    if (game_state !== exp_state) begin
      $display("FAIL %s state: got %b want %b", name, game_state, exp_state);
      miscompares++;
    end
    vectors++;
    if (grid !== exp_grid) begin
      $display("FAIL %s grid: got %h want %h", name, grid, exp_grid);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check_out("reset", 2'b00, '0);
    // pp register was cleared by reset, so a held pp now reads as an edge
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("idle_pp_to_run", 2'b10, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("run_pp_held", 2'b10, '0);
    do_reset();
    check_out("reset_again", 2'b00, '0);
  endtask

  task automatic test_program();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("prgm_enter", 2'b01, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out("prgm_seq", 2'b01, 49'h0CBE);
    // 37 more dead writes bring the total to 49, cursor back at 0
    for (int i = 0; i < 37; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("prgm_49", 2'b01, 49'h0CBE);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out("wrap_50th", 2'b01, 49'h0CBF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("wrap_51st", 2'b01, 49'h0CBD);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_out("both_btns", 2'b01, 49'h0CBD);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("cursor_held", 2'b01, 49'h0CB9);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_out("prgm_held", 2'b01, 49'h0CB1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_out("pp_beats_btn", 2'b10, 49'h0CB1);
  endtask

  task automatic test_blinker();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 23; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out("blink_loaded", 2'b01, H_BLINK);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("blink_enter", 2'b10, H_BLINK);
    // buttons held high in RUN must be ignored
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_out("blink_gen", 2'b10, (i % 2 == 1) ? V_BLINK : H_BLINK);
    end
  endtask

  task automatic test_pause_resume();
    // continues from the blinker: RUN with vertical phase showing
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("pause_enter", 2'b11, V_BLINK);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_out("pause_frozen", 2'b11, V_BLINK);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("held_pp_1", 2'b10, V_BLINK);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("held_pp_2", 2'b10, H_BLINK);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("held_pp_3", 2'b10, V_BLINK);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("run_low", 2'b10, H_BLINK);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("pause_again", 2'b11, H_BLINK);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("pause_hold", 2'b11, H_BLINK);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("resume", 2'b10, H_BLINK);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("resume_gen", 2'b10, V_BLINK);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_out("reset_mid_run", 2'b00, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("after_reset", 2'b00, '0);
  endtask

  task automatic test_corner();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out("idle_btn_ignored", 2'b00, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out("corner_loaded", 2'b01, 49'h083);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("corner_enter", 2'b10, 49'h083);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_out("corner_block", 2'b10, 49'h183);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("run_to_prgm", 2'b01, 49'h183);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("prgm_cursor_zero", 2'b01, 49'h182);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clkb = 1'b0;
    stop = 1'b1; prgm = 1'b0; pp = 1'b0; btn0 = 1'b0; btn1 = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_program();
    test_blinker();
    test_pause_resume();
    test_corner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
